// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive MAC filter.
// Holds the filter state enumeration, frame field lengths and the
// destination-address match rule.
package eth_rx_pkg;

  localparam int          ETH_DA_LEN     = 6;
  localparam int          ETH_FCS_LEN    = 4;
  localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PASS,
    ST_FLUSH,
    ST_DROP
  } eth_rx_state_t;

  // Accept rule for a completed destination address. Bit 40 is bit 0 of
  // the first byte on the wire, i.e. the group (multicast) bit.
  function automatic logic da_match(input logic [47:0] da,
                                    input logic [47:0] mac,
                                    input logic        promisc,
                                    input logic        bcast_en,
                                    input logic        mcast_en);
    return promisc
        || (da == mac)
        || (bcast_en && (da == ETH_BCAST_ADDR))
        || (mcast_en && da[40]);
  endfunction

endpackage

// File: rtl/axis_eth_rx_mac_filter.sv
// Receive-side destination-MAC filter and FCS stripper.
// Buffers the first 6 bytes (the DA) so the accept/drop decision is made
// before anything is forwarded; once accepted, the same 6-byte delay line
// keeps the trailing FCS bytes from ever reaching the output.
// Optional build macro: ETH_RX_FILTER_STATS_EN enables the 32-bit frame
// counters on stat_rx_frames / stat_rx_dropped (tied to 0 otherwise).
module axis_eth_rx_mac_filter
  import eth_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic [47:0]           cfg_mac_addr,
  input  logic                  cfg_promisc,
  input  logic                  cfg_bcast_en,
  input  logic                  cfg_mcast_en,
  output logic                  frame_dropped,
  output logic                  error_runt,
  output logic                  error_giant,
  output logic [31:0]           stat_rx_frames,
  output logic [31:0]           stat_rx_dropped
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("axis_eth_rx_mac_filter: DATA_WIDTH must be 8");
  end

  // Bytes still in the delay line at tlast that are payload, not FCS.
  localparam int          FLUSH_BYTES = ETH_DA_LEN - ETH_FCS_LEN;
  localparam logic [2:0]  FLUSH_LAST  = 3'(FLUSH_BYTES - 1);
  localparam logic [15:0] HDR_LAST    = 16'(ETH_DA_LEN - 1);
  localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

  eth_rx_state_t state;

  // dl[0] is always the oldest byte held.
  logic [ETH_DA_LEN-1:0][DATA_WIDTH-1:0] dl;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [2:0]  flush_cnt;
  logic        flush_viol;
  logic        tuser_q;
  logic        runt_q;
  logic        giant_q;
  logic [47:0] da_now;

  // Byte count saturates so giant frames of any length stay flagged.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Full DA as it stands when the 6th byte is on the input.
  assign da_now = {dl[0], dl[1], dl[2], dl[3], dl[4], s_axis_tdata};

  // Frame state machine, delay line and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dl            <= '0;
      flush_cnt     <= '0;
      flush_viol    <= 1'b0;
      tuser_q       <= 1'b0;
      runt_q        <= 1'b0;
      giant_q       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_dropped <= 1'b0;
      error_runt    <= 1'b0;
      error_giant   <= 1'b0;
    end else begin
      // Every output is a one-cycle strobe unless a state below drives it.
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_dropped <= 1'b0;
      error_runt    <= 1'b0;
      error_giant   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            dl[0] <= s_axis_tdata;
            cnt   <= 16'd1;
            if (s_axis_tlast) begin
              // Single-byte frame: runt, nothing forwarded.
              frame_dropped <= 1'b1;
              error_runt    <= 1'b1;
            end else begin
              state <= ST_HEADER;
            end
          end
        end

        ST_HEADER: begin
          if (s_axis_tvalid) begin
            for (int i = 1; i < ETH_DA_LEN; i++) begin
              if (cnt[2:0] == 3'(i)) dl[i] <= s_axis_tdata;
            end
            cnt <= cnt_inc;
            if (s_axis_tlast) begin
              frame_dropped <= 1'b1;
              error_runt    <= 1'b1;
              state         <= ST_IDLE;
            end else if (cnt == HDR_LAST) begin
              state <= da_match(da_now, cfg_mac_addr, cfg_promisc,
                                cfg_bcast_en, cfg_mcast_en) ? ST_PASS : ST_DROP;
            end
          end
        end

        ST_PASS: begin
          if (s_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= dl[0];
            for (int i = 0; i < ETH_DA_LEN-1; i++) dl[i] <= dl[i+1];
            dl[ETH_DA_LEN-1] <= s_axis_tdata;
            cnt <= cnt_inc;
            if (s_axis_tlast) begin
              // cnt_inc is the final frame length including FCS.
              tuser_q    <= s_axis_tuser;
              runt_q     <= (cnt_inc < MIN_L);
              giant_q    <= (cnt_inc > MAX_L);
              flush_cnt  <= '0;
              flush_viol <= 1'b0;
              state      <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          // Drains the remaining payload regardless of input valid; any
          // beat seen here is an overlapping frame and gets discarded.
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= dl[0];
          for (int i = 0; i < ETH_DA_LEN-1; i++) dl[i] <= dl[i+1];
          dl[ETH_DA_LEN-1] <= '0;
          if (s_axis_tvalid) flush_viol <= 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= tuser_q | runt_q | giant_q;
            error_runt   <= runt_q;
            error_giant  <= giant_q;
            state        <= (flush_viol || s_axis_tvalid) ? ST_DROP : ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
          end
        end

        ST_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            frame_dropped <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ETH_RX_FILTER_STATS_EN
  // Forwarded / discarded frame counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rx_frames  <= '0;
      stat_rx_dropped <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tlast) stat_rx_frames  <= stat_rx_frames + 32'd1;
      if (frame_dropped)                 stat_rx_dropped <= stat_rx_dropped + 32'd1;
    end
  end
`else
  assign stat_rx_frames  = '0;
  assign stat_rx_dropped = '0;
`endif

endmodule

// File: tb/tb_axis_eth_rx_mac_filter.sv
// Directed bench for axis_eth_rx_mac_filter. A frame-level model turns each
// input frame into the expected output beats and status pulses; a monitor
// compares every output beat against it, and each test also pins the
// outcome with hand-computed literals.
`timescale 1ns/1ps
module tb_axis_eth_rx_mac_filter;

`ifdef ETH_RX_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [47:0] cfg_mac_addr = MAC;
  logic        cfg_promisc = 1'b0, cfg_bcast_en = 1'b0, cfg_mcast_en = 1'b0;
  logic        frame_dropped, error_runt, error_giant;
  logic [31:0] stat_rx_frames, stat_rx_dropped;

  axis_eth_rx_mac_filter dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc),
    .cfg_bcast_en(cfg_bcast_en), .cfg_mcast_en(cfg_mcast_en),
    .frame_dropped(frame_dropped), .error_runt(error_runt),
    .error_giant(error_giant),
    .stat_rx_frames(stat_rx_frames), .stat_rx_dropped(stat_rx_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  int n_checks = 0, n_pass = 0, cyc = 0, t_tlast_in = -100;
  bit mon_en = 1'b0;
  // Observed (monitor) cumulative counts.
  int n_beats = 0, n_drop_p = 0, n_runt_p = 0, n_giant_p = 0;
  logic last_user = 1'b0;
  // Model state.
  beat_t exp_q[$];
  beat_t mon_e;
  int exp_drop = 0, exp_runt = 0, exp_giant = 0;
  int exp_frames = 0, exp_dropped = 0;
  logic [7:0] frm[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endtask

  // Monitor: every output beat must be the next beat the model predicted.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_axis_tvalid) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, mon_e.d);
          chk("tlast", m_axis_tlast, mon_e.l);
          if (mon_e.l) chk("tuser", m_axis_tuser, mon_e.u);
        end
        if (m_axis_tlast) begin
          last_user = m_axis_tuser;
          chk("tlast_latency", cyc - t_tlast_in, 2);
        end
      end else begin
        chk("idle_tdata", m_axis_tdata, 0);
      end
      if (frame_dropped) n_drop_p++;
      if (error_runt)    n_runt_p++;
      if (error_giant)   n_giant_p++;
      if (error_giant) chk("giant_on_last", m_axis_tvalid && m_axis_tlast, 1);
      if (error_runt)  chk("runt_timing", (m_axis_tvalid && m_axis_tlast) || frame_dropped, 1);
    end
  end

  task automatic build_frame(input int n, input logic [47:0] da);
    frm.delete();
    for (int i = 0; i < n; i++) begin
      if (i < 6) frm.push_back(da[47-8*i -: 8]);
      else       frm.push_back(8'(i*13 + n));
    end
  endtask

  // Frame-level rules: length, DA acceptance, FCS removal, error flags.
  task automatic model_frame(input logic usr, input bit force_drop);
    int n = frm.size();
    logic [47:0] da = '0;
    bit hit;
    beat_t b;
    for (int i = 0; i < 6; i++) if (i < n) da = {da[39:0], frm[i]};
    hit = cfg_promisc || (da == cfg_mac_addr) || (cfg_bcast_en && da == BCAST)
       || (cfg_mcast_en && da[40]);
    if (n <= 6) begin
      exp_drop++; exp_runt++; exp_dropped++;
    end else if (!hit || force_drop) begin
      exp_drop++; exp_dropped++;
    end else begin
      for (int i = 0; i < n-4; i++) begin
        b.d = frm[i];
        b.l = (i == n-5);
        b.u = b.l ? (usr || n < 64 || n > 1518) : 1'b0;
        exp_q.push_back(b);
      end
      exp_frames++;
      if (n < 64)   exp_runt++;
      if (n > 1518) exp_giant++;
    end
  endtask

  // Frame cut after k bytes: only bytes already pushed past the DA window appear.
  task automatic model_partial(input int k);
    beat_t b;
    for (int i = 0; i < k-6; i++) begin
      b.d = frm[i]; b.l = 1'b0; b.u = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive(input logic usr, input bit mii, input int stop_at, input bit idle_after);
    int n = frm.size();
    int lim = (stop_at >= 0) ? stop_at : n;
    for (int i = 0; i < lim; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frm[i];
      s_axis_tlast  = (i == n-1);
      s_axis_tuser  = (i == n-1) ? usr : 1'b0;
      @(posedge clk); #1;
      if (i == n-1) t_tlast_in = cyc;
      if (mii) begin
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = '0;
        @(posedge clk); #1;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = '0;
    if (idle_after) repeat (12) begin @(posedge clk); #1; end
  endtask

  task automatic check_stats(input string nm);
    chk({nm, "_stat_frames"},  stat_rx_frames,  STATS ? 32'(exp_frames)  : 32'd0);
    chk({nm, "_stat_dropped"}, stat_rx_dropped, STATS ? 32'(exp_dropped) : 32'd0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_tvalid"}, m_axis_tvalid, 0);
    chk({nm, "_tlast"},  m_axis_tlast, 0);
    chk({nm, "_tuser"},  m_axis_tuser, 0);
    chk({nm, "_tdata"},  m_axis_tdata, 0);
    chk({nm, "_dropped"}, frame_dropped, 0);
    chk({nm, "_runt"},   error_runt, 0);
    chk({nm, "_giant"},  error_giant, 0);
    chk({nm, "_stat_frames"},  stat_rx_frames, 0);
    chk({nm, "_stat_dropped"}, stat_rx_dropped, 0);
  endtask

  task automatic check_totals(input string nm);
    chk({nm, "_queue_drained"}, exp_q.size(), 0);
    chk({nm, "_drop_total"},  n_drop_p,  exp_drop);
    chk({nm, "_runt_total"},  n_runt_p,  exp_runt);
    chk({nm, "_giant_total"}, n_giant_p, exp_giant);
    check_stats(nm);
  endtask

  task automatic run_frame(input string nm, input int n, input logic [47:0] da,
                           input logic usr, input bit mii, input int lit_beats,
                           input logic lit_user, input int lit_drop,
                           input int lit_runt, input int lit_giant);
    int b0 = n_beats, d0 = n_drop_p, r0 = n_runt_p, g0 = n_giant_p;
    build_frame(n, da);
    model_frame(usr, 1'b0);
    drive(usr, mii, -1, 1'b1);
    chk({nm, "_beats"}, n_beats - b0, lit_beats);
    if (lit_beats > 0) chk({nm, "_last_user"}, last_user, lit_user);
    chk({nm, "_drop_pulses"},  n_drop_p - d0,  lit_drop);
    chk({nm, "_runt_pulses"},  n_runt_p - r0,  lit_runt);
    chk({nm, "_giant_pulses"}, n_giant_p - g0, lit_giant);
    check_totals(nm);
  endtask

  initial begin
    int b0, d0;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_zero("por");
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // MII rate, then a second frame cut by reset.
    run_frame("mii64", 64, MAC, 1'b0, 1'b1, 60, 1'b0, 0, 0, 0);
    b0 = n_beats;
    build_frame(64, MAC);
    model_partial(30);
    drive(1'b0, 1'b1, 30, 1'b0);
    chk("mii_abort_beats", n_beats - b0, 24);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_frames = 0; exp_dropped = 0;
    check_zero("mid_rst");
    b0 = n_beats;
    repeat (12) begin @(posedge clk); #1; end
    chk("post_rst_quiet", n_beats - b0, 0);
    check_totals("post_rst");

    // GMII back-to-back frames.
    run_frame("gmii64",    64,   MAC,   1'b0, 1'b0, 60,   1'b0, 0, 0, 0);
    run_frame("nomatch",   64,   OTHER, 1'b0, 1'b0, 0,    1'b0, 1, 0, 0);
    cfg_promisc = 1'b1;
    run_frame("promisc",   64,   OTHER, 1'b0, 1'b0, 60,   1'b0, 0, 0, 0);
    cfg_promisc = 1'b0;
    cfg_bcast_en = 1'b1;
    run_frame("bcast40",   40,   BCAST, 1'b0, 1'b0, 36,   1'b1, 0, 1, 0);
    cfg_bcast_en = 1'b0;
    run_frame("bcast_off", 40,   BCAST, 1'b0, 1'b0, 0,    1'b0, 1, 0, 0);
    run_frame("runt5",     5,    MAC,   1'b0, 1'b0, 0,    1'b0, 1, 1, 0);
    run_frame("runt6",     6,    MAC,   1'b0, 1'b0, 0,    1'b0, 1, 1, 0);
    run_frame("min7",      7,    MAC,   1'b0, 1'b0, 3,    1'b1, 0, 1, 0);
    run_frame("len63",     63,   MAC,   1'b0, 1'b0, 59,   1'b1, 0, 1, 0);
    run_frame("giant1519", 1519, MAC,   1'b0, 1'b0, 1515, 1'b1, 0, 0, 1);
    run_frame("max1518",   1518, MAC,   1'b0, 1'b0, 1514, 1'b0, 0, 0, 0);
    run_frame("tuser100",  100,  MAC,   1'b1, 1'b0, 96,   1'b1, 0, 0, 0);
    cfg_mcast_en = 1'b1;
    run_frame("mcast",     64,   MCAST, 1'b0, 1'b0, 60,   1'b0, 0, 0, 0);
    cfg_mcast_en = 1'b0;

    // Second frame starting while the first is still flushing.
    b0 = n_beats; d0 = n_drop_p;
    build_frame(64, MAC);
    model_frame(1'b0, 1'b0);
    drive(1'b0, 1'b0, -1, 1'b0);
    build_frame(64, MAC);
    model_frame(1'b0, 1'b1);
    drive(1'b0, 1'b0, -1, 1'b1);
    chk("overlap_beats", n_beats - b0, 60);
    chk("overlap_drop_pulses", n_drop_p - d0, 1);
    check_totals("overlap");
    run_frame("recover",   64,   MAC,   1'b0, 1'b0, 60,   1'b0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_eth_rx_mac_filter.md
# axis_eth_rx_mac_filter

Receive-side stage consuming the 8-bit valid-only AXI stream produced by the GMII frame receiver. It filters frames on destination MAC address and strips the 4-byte FCS. It flags runt and giant frames in tuser and emits a valid-only AXI stream to the MAC RX FIFO. A 6-byte delay line lets the accept/drop decision be made before any byte of the frame is forwarded.

## Interface
- DATA_WIDTH, 8, stream width; any other value is an elaboration error
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included
- MAX_LEN, 1518, maximum legal frame length in bytes, FCS included
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- s_axis_tdata  in  8  frame byte
- s_axis_tvalid  in  1  byte valid; no tready, every valid beat is consumed
- s_axis_tlast  in  1  last byte of frame (last FCS byte)
- s_axis_tuser  in  1  bad frame, meaningful on last beat
- m_axis_tdata  out  8  payload byte, DA first
- m_axis_tvalid  out  1  byte valid; no tready
- m_axis_tlast  out  1  last payload byte
- m_axis_tuser  out  1  bad frame, meaningful on last beat
- cfg_mac_addr  in  48  local MAC; first received byte compares with [47:40]
- cfg_promisc  in  1  accept every frame
- cfg_bcast_en  in  1  accept DA FF:FF:FF:FF:FF:FF
- cfg_mcast_en  in  1  accept DA with bit 0 of first byte set
- frame_dropped  out  1  one-cycle pulse per discarded frame
- error_runt  out  1  one-cycle pulse, length < MIN_LEN
- error_giant  out  1  one-cycle pulse, length > MAX_LEN
- stat_rx_frames  out  32  frames forwarded (see Configuration)
- stat_rx_dropped  out  32  frames discarded (see Configuration)

## Operation
- States: IDLE, HEADER, PASS, FLUSH, DROP.
- Delay line: 6 bytes. Byte counter: 16 bits, saturating at 0xFFFF, cleared at the start of each frame.
- IDLE: the first valid beat is stored in slot 0, then → HEADER.
- HEADER: bytes are stored in order.
  - On the 6th byte, evaluate the match: cfg_promisc, or DA == cfg_mac_addr, or (DA all-ones and cfg_bcast_en), or (DA bit 0 set and cfg_mcast_en).
  - Match → PASS. No match → DROP.
  - tlast before or on the 6th byte → IDLE with frame_dropped and error_runt pulses; nothing is output.
  - Config inputs are sampled only at the 6th byte.
- PASS: each valid beat outputs the oldest delay-line byte and shifts the new byte in. On the tlast beat, the output is non-last, the final tuser is latched, and the state goes to FLUSH.
- FLUSH: emits the 2 remaining payload bytes on 2 consecutive cycles, independent of s_axis_tvalid. tlast is set on the second byte. The 4 FCS bytes are discarded. Then → IDLE.
  - Output length is N−4 for input length N ≥ 7.
- Output tuser on the last beat = latched s_axis_tuser OR (N < MIN_LEN) OR (N > MAX_LEN).
  - error_runt pulses with the output last beat when N < MIN_LEN.
  - error_giant pulses with the output last beat when N > MAX_LEN.
- DROP: discards beats until tlast, then → IDLE. frame_dropped pulses on the cycle after tlast.
- A valid beat arriving during FLUSH is a protocol violation (the upstream preamble gap is ≥ 8 cycles). Required behaviour: the beat is ignored, the state after FLUSH is DROP, and the rest of that frame is discarded.
- m_axis_tdata is 0 whenever m_axis_tvalid is 0.

## Timing
- All outputs are registered.
- In PASS, byte k appears on m_axis the cycle after input byte k+6 is accepted.
- The last payload byte appears 2 cycles after input tlast.
- Gaps in s_axis_tvalid (MII half-rate) propagate to the output as gaps, except during FLUSH.
- Reset values: state IDLE, counter 0. These outputs reset to 0: m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, frame_dropped, error_runt, error_giant, stat_rx_frames, stat_rx_dropped.
- Reset mid-frame: the partial frame is abandoned with no tlast emitted. The first beat after reset deasserts is treated as a frame start.

## Configuration
- ETH_RX_FILTER_STATS_EN defined: stat_rx_frames increments on each output tlast, and stat_rx_dropped increments on each frame_dropped pulse.
  - Both counters are 32-bit and wrap at 2^32.
  - Both clear on rst.
- Macro not defined: both stat ports are constant 0 and no counter logic is built.

## Structure
- Shared package eth_rx_pkg holds:
  - the state enumeration;
  - ETH_DA_LEN = 6, ETH_FCS_LEN = 4, ETH_BCAST_ADDR = 48'hFFFFFFFFFFFF.
- No sub-module: the delay line and match logic are small and stay inline.

## Test plan
- 64-byte frame (60 payload + FCS), DA == cfg_mac_addr, back-to-back GMII rate → 60 output bytes identical to input bytes 0..59, tlast on byte 59, tuser 0, no status pulses.
- DA 02:00:00:00:00:99 with cfg_mac_addr 02:00:00:00:00:01 and promisc/bcast/mcast all 0 → no output, frame_dropped pulses once. Same frame with cfg_promisc=1 → forwarded.
- Broadcast DA, 40-byte frame, cfg_bcast_en=1 → 36 bytes out, tuser 1, error_runt pulse. Same with cfg_bcast_en=0 → dropped.
- 5-byte frame ending with tlast → no output, error_runt and frame_dropped pulse.
- 1519-byte frame with input tuser 0 → 1515 bytes out, tuser 1, error_giant pulse. 100-byte frame with input tuser 1 on last → 96 bytes out, tuser 1.
- MII-rate input (valid every other cycle), 64-byte frame, then rst asserted mid-second-frame → first frame correct. Second frame output stops with no tlast. Stat counters read frames=1, dropped=0 before reset and 0 after.
